port_bus_arbiter: RTL and testbench
===================================

Name: port_bus_arbiter

Overview:
Shares the single 8-bit peripheral bus (abus/dbus/wr_en/rd_en) that feeds the port_io blocks among NUM_REQ requesters. Each requester posts one read or write. The block arbitrates, sequences the bus strobes with a fixed setup and turnaround, and returns read data with a one-cycle ack. It sits between the core/DMA-side masters and the port_io instances.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
RD_LAT, 1, cycles rd_en is held before dbus is sampled (1..3).

Ports:
clk_in  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
req  input  NUM_REQ  per-requester request level
req_we  input  NUM_REQ  1 = write, 0 = read
req_addr  input  NUM_REQ*8  flat address bus; requester i uses bits [8i+7:8i]
req_wdata  input  NUM_REQ*8  flat write data, same packing
ack  output  NUM_REQ  one-cycle completion pulse per requester
rdata  output  8  read data, valid while any ack bit is high for a read
gnt_id  output  2  index of the current owner
busy  output  1  high whenever the FSM is outside IDLE
abus  output  8  peripheral address
dbus  inout  8  peripheral data; driven only in WRITE, otherwise Z
wr_en  output  1  peripheral write strobe
rd_en  output  1  peripheral read strobe

Behaviour:
- Reset (async, rst=1): state IDLE, abus=0, wr_en=0, rd_en=0, dbus=Z, ack=0, rdata=0, gnt_id=0, busy=0, rr pointer=0.
- FSM states: IDLE, SETUP, WRITE, READ, DONE.
- IDLE: if any req bit is high at a clock edge, pick the winner and latch its addr, wdata and we. Set gnt_id and go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): abus = latched addr; strobes low; dbus=Z. Next state is WRITE if we=1, else READ.
- WRITE (1 cycle): wr_en=1; dbus = latched wdata; abus held. Next state DONE.
- READ (RD_LAT cycles, counted by a 2-bit counter): rd_en=1; abus held. On the final READ edge, capture dbus into rdata. Next state DONE.
- DONE (1 cycle): strobes low; dbus=Z; ack[gnt_id]=1; rdata held. Update rr pointer to (gnt_id+1) mod NUM_REQ. Next state IDLE.
- Latency, req sampled at edge k: write ack is high in cycle k+3; read ack is high in cycle k+2+RD_LAT. Minimum gap between transactions is one IDLE cycle, which is the bus turnaround.
- Requester rules: hold req, we, addr and wdata stable until ack. Dropping req mid-transaction does not abort it: the transaction completes and ack still pulses. If req is still high in the cycle after ack, it is a new request.
- Simultaneous requests: at most one winner per IDLE decision; losers wait with no ack.
- rdata is not modified by writes; it holds its last captured value.
- The block does no address decoding; base-address matching belongs to port_io.
- A reset mid-transaction aborts immediately: no ack is issued and the bus is released the same cycle.

Optional Feature:
PORT_ARB_ROUND_ROBIN_EN
- Defined: round-robin. The search starts at the rr pointer and wraps, so every active requester is served within NUM_REQ transactions.
- Undefined: fixed priority; the lowest index wins. The rr pointer is not implemented (removed from the logic), and requester 0 can starve the others.

Decomposition:
- Package port_bus_pkg holds: state enum (IDLE, SETUP, WRITE, READ, DONE), ADDR_W=8, DATA_W=8, MAX_REQ=4.
- Sub-module port_arb_pick, purely combinational:
  - inputs: req vector and pointer;
  - outputs: winner index and a valid flag;
  - switches between round-robin and fixed priority on the macro.
- The FSM, latches and tristate control stay in port_bus_arbiter.

Test Plan:
1. Req0 writes addr 0x00 with data 0xA5 at edge k -> abus=0x00 in k+1; wr_en=1 and dbus=0xA5 only in k+2; ack[0] in k+3; dbus Z otherwise.
2. Req1 reads addr 0x00 with RD_LAT=1; bus model returns 0x3C while rd_en=1 -> rd_en high for exactly 1 cycle; ack[1] and rdata=0x3C in k+3. Repeat with RD_LAT=3: ack in k+5.
3. Req0 and req1 both held high for 4 transactions, macro defined -> grant order 0,1,0,1. Macro undefined -> order 0,0,0,0; req1 gets no ack.
4. Assert rst in a READ cycle -> rd_en=0, dbus=Z, busy=0 immediately; no ack; after release, a new req0 write completes normally.
5. Req0 drops in SETUP -> the transaction still completes and ack[0] pulses once; no second transaction follows.
6. Back-to-back writes from req0 (0x11 then 0x22) with req held -> two acks 4 cycles apart, one IDLE cycle between DONE and the next SETUP.

Source files
------------

// File: rtl/port_bus_pkg.sv
// Shared types and constants for the port bus arbiter.
// Build option: PORT_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
package port_bus_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int MAX_REQ = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Next requester index after id, wrapping at n.
    function automatic logic [1:0] next_id(input logic [1:0] id, input int n);
        return (int'(id) + 1 >= n) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

// File: rtl/port_arb_pick.sv
// Combinational winner selection for the port bus arbiter.
// PORT_ARB_ROUND_ROBIN_EN defined: search starts at ptr and wraps.
// PORT_ARB_ROUND_ROBIN_EN undefined: lowest requesting index wins, ptr ignored.
module port_arb_pick
    import port_bus_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         winner,
    output logic               valid
);

`ifdef PORT_ARB_ROUND_ROBIN_EN
    logic [2*NUM_REQ-1:0] rotated;
    int                   pos;

    // First set bit at or after ptr, wrapping past the top requester.
    always_comb begin
        // NOTE: every output gets a default before the search so no path infers a latch.
        winner  = '0;
        valid   = 1'b0;
        pos     = 0;
        rotated = {req, req} >> ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && rotated[i]) begin
                valid = 1'b1;
                pos   = i + int'(ptr);
                if (pos >= NUM_REQ) pos = pos - NUM_REQ;
                winner = 2'(pos);
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Lowest index with a pending request wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[i]) begin
                valid  = 1'b1;
                winner = 2'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/port_bus_arbiter.sv
// Shares the 8-bit peripheral bus among NUM_REQ requesters: arbitrates,
// sequences SETUP / WRITE or READ / DONE, and returns a one-cycle ack.
// Build option: PORT_ARB_ROUND_ROBIN_EN enables the round-robin pointer;
// without it the lowest index always wins.
module port_bus_arbiter
    import port_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int RD_LAT  = 1
) (
    input  logic                      clk_in,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic [1:0]                gnt_id,
    output logic                      busy,
    output logic [ADDR_W-1:0]         abus,
    inout  wire  [DATA_W-1:0]         dbus,
    output logic                      wr_en,
    output logic                      rd_en
);

    state_t              state;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic [1:0]          rd_cnt;

    logic [1:0]          winner;
    logic                win_valid;
    logic [1:0]          pick_ptr;

    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    port_arb_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .winner (winner),
        .valid  (win_valid)
    );

`ifdef PORT_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;

    // Advance the search start past the requester just served.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst)                rr_ptr <= '0;
        else if (state == DONE) rr_ptr <= next_id(gnt_id, NUM_REQ);
    end

    assign pick_ptr = rr_ptr;
`else
    assign pick_ptr = '0;
`endif

    // Route the winning requester's fields from the flat input buses.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == 2'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Transaction sequencer; abus doubles as the latched address.
    always_ff @(posedge clk_in or posedge rst) begin
        // NOTE: non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state   <= IDLE;
            abus    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            gnt_id  <= '0;
            rd_cnt  <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        abus    <= sel_addr;
                        wdata_q <= sel_wdata;
                        we_q    <= sel_we;
                        gnt_id  <= winner;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    rd_cnt <= '0;
                    state  <= we_q ? WRITE : READ;
                end
                WRITE: state <= DONE;
                READ: begin
                    if (rd_cnt == 2'(RD_LAT - 1)) begin
                        rdata <= dbus;
                        state <= DONE;
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes, ack and bus drive decode straight from state, so a reset
    // releases the bus in the same cycle it is asserted.
    assign busy  = (state != IDLE);
    assign wr_en = (state == WRITE);
    assign rd_en = (state == READ);
    assign ack   = (state == DONE) ? (NUM_REQ'(1) << gnt_id) : '0;
    assign dbus  = wr_en ? wdata_q : 'z;

endmodule

// File: tb/tb_port_bus_arbiter.sv
// Randomized scoreboard bench for port_bus_arbiter: requester agents,
// a transaction-level reference model, a peripheral memory on the bus,
// and a monitor that checks every strobe cycle and every ack.
module tb_port_bus_arbiter;

    localparam int NUM_REQ = 3;
    localparam int RD_LAT  = 3;

    typedef struct {
        int         cyc;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_ev_t;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] rdata;
    } ack_ev_t;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_we;
    logic [NUM_REQ*8-1:0] req_addr;
    logic [NUM_REQ*8-1:0] req_wdata;
    logic [NUM_REQ-1:0]   ack;
    logic [7:0]           rdata;
    logic [1:0]           gnt_id;
    logic                 busy;
    logic [7:0]           abus;
    wire  [7:0]           dbus;
    logic                 wr_en;
    logic                 rd_en;

    port_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk_in    (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .abus      (abus),
        .dbus      (dbus),
        .wr_en     (wr_en),
        .rd_en     (rd_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral side: a 256-byte memory written on wr_en, driving dbus on rd_en.
    logic [7:0] per_mem [256];
    always @(posedge clk) if (wr_en) per_mem[abus] <= dbus;
    assign dbus = rd_en ? per_mem[abus] : 8'bz;

    int n_cmp = 0;
    int n_err = 0;
    int n_ack = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model state.
    bus_ev_t    bus_q[$];
    ack_ev_t    ack_q[$];
    logic [7:0] shadow [256];
    logic [7:0] last_rd;
    int         free_edge;
    int         m_rr;
    bit         rand_en;

    // Requester agents.
    logic       a_req   [NUM_REQ];
    logic       a_we    [NUM_REQ];
    logic [7:0] a_addr  [NUM_REQ];
    logic [7:0] a_wdata [NUM_REQ];
    bit         granted [NUM_REQ];
    int         gnt_edge[NUM_REQ];
    int         done_cyc[NUM_REQ];

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i]              = a_req[i];
            req_we[i]           = a_we[i];
            req_addr[i*8 +: 8]  = a_addr[i];
            req_wdata[i*8 +: 8] = a_wdata[i];
        end
    endtask

    task automatic new_txn(input int i);
        a_req[i]   = 1'b1;
        a_we[i]    = 1'($urandom_range(0, 1));
        a_addr[i]  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
        a_wdata[i] = 8'($urandom);
    endtask

    task automatic reset_model();
        bus_q.delete();
        ack_q.delete();
        last_rd   = 8'h00;
        free_edge = 0;
        m_rr      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_req[i]   = 1'b0;
            granted[i] = 1'b0;
        end
    endtask

    // One negedge of stimulus: agents react, then the model decides the
    // arbitration that happens on the coming rising edge (edge number cyc+1).
    task automatic step();
        int w;
        int idx;
        int e;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (granted[i] && cyc == done_cyc[i] + 1) begin
                granted[i] = 1'b0;
                if (rand_en && $urandom_range(0, 2) != 0) new_txn(i);
                else a_req[i] = 1'b0;
            end else if (granted[i] && cyc == gnt_edge[i] && a_req[i]) begin
                if (rand_en && $urandom_range(0, 3) == 0) a_req[i] = 1'b0;
            end else if (!granted[i] && !a_req[i]) begin
                if (rand_en && $urandom_range(0, 3) == 0) new_txn(i);
                else begin
                    a_we[i]    = 1'($urandom_range(0, 1));
                    a_addr[i]  = 8'($urandom);
                    a_wdata[i] = 8'($urandom);
                end
            end
        end
        if (cyc + 1 >= free_edge) begin
            w = -1;
            for (int o = 0; o < NUM_REQ; o++) begin
`ifdef PORT_ARB_ROUND_ROBIN_EN
                idx = (m_rr + o) % NUM_REQ;
`else
                idx = o;
`endif
                if (w < 0 && a_req[idx]) w = idx;
            end
            if (w >= 0) begin
                e           = cyc + 1;
                granted[w]  = 1'b1;
                gnt_edge[w] = e;
                if (a_we[w]) begin
                    bus_q.push_back('{e + 1, 1'b1, a_addr[w], a_wdata[w]});
                    shadow[a_addr[w]] = a_wdata[w];
                    done_cyc[w] = e + 2;
                    free_edge   = e + 4;
                end else begin
                    for (int j = 0; j < RD_LAT; j++)
                        bus_q.push_back('{e + 1 + j, 1'b0, a_addr[w], 8'h00});
                    last_rd     = shadow[a_addr[w]];
                    done_cyc[w] = e + 1 + RD_LAT;
                    free_edge   = e + 3 + RD_LAT;
                end
                ack_q.push_back('{done_cyc[w], w, last_rd});
                m_rr = (w + 1) % NUM_REQ;
            end
        end
        drive();
    endtask

    // Monitor: compares every strobe cycle and every ack against the queues.
    always @(negedge clk) begin
        ack_ev_t a;
        bus_ev_t b;
        if (!rst) begin
            if (ack != '0) begin
                n_ack++;
                if (ack_q.size() == 0) begin
                    check("ack_spurious", 32'(ack), 32'(0));
                end else begin
                    a = ack_q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(a.cyc));
                    check("ack_vector", 32'(ack), 32'(1) << a.id);
                    check("ack_gnt_id", 32'(gnt_id), 32'(a.id));
                    check("ack_rdata", 32'(rdata), 32'(a.rdata));
                end
            end else if (ack_q.size() != 0 && ack_q[0].cyc < cyc) begin
                a = ack_q.pop_front();
                check("ack_missing", 32'(ack), 32'(1) << a.id);
            end
            if (wr_en || rd_en) begin
                if (bus_q.size() == 0) begin
                    check("strobe_spurious", {30'd0, wr_en, rd_en}, 32'(0));
                end else begin
                    b = bus_q.pop_front();
                    check("strobe_cycle", 32'(cyc), 32'(b.cyc));
                    check("strobe_kind", {30'd0, wr_en, rd_en}, b.wr ? 32'd2 : 32'd1);
                    check("abus", 32'(abus), 32'(b.addr));
                    if (b.wr) check("dbus_wdata", 32'(dbus), 32'(b.data));
                end
            end else if (bus_q.size() != 0 && bus_q[0].cyc < cyc) begin
                b = bus_q.pop_front();
                check("strobe_missing", {30'd0, wr_en, rd_en}, b.wr ? 32'd2 : 32'd1);
            end
        end
    end

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            step();
            done = (bus_q.size() == 0) && (ack_q.size() == 0);
            for (int i = 0; i < NUM_REQ; i++) if (a_req[i] || granted[i]) done = 1'b0;
        end
        if (!done) check(name, 32'(ack_q.size() + bus_q.size()), 32'(0));
    endtask

    initial begin
        int base;
        int e;
        bit seen;
        rst     = 1'b1;
        rand_en = 1'b0;
        for (int a = 0; a < 256; a++) begin
            shadow[a]  = 8'(a * 7 + 3);
            per_mem[a] = 8'(a * 7 + 3);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            a_we[i]    = 1'b0;
            a_addr[i]  = 8'h00;
            a_wdata[i] = 8'h00;
        end
        reset_model();
        drive();
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),   32'(0));
        check("rst_ack",    32'(ack),    32'(0));
        check("rst_rdata",  32'(rdata),  32'(0));
        check("rst_gnt_id", 32'(gnt_id), 32'(0));
        check("rst_wr_en",  32'(wr_en),  32'(0));
        check("rst_rd_en",  32'(rd_en),  32'(0));
        check("rst_abus",   32'(abus),   32'(0));
        rst = 1'b0;

        // Randomized traffic from all requesters.
        rand_en = 1'b1;
        repeat (3000) begin
            @(negedge clk);
            step();
        end
        rand_en = 1'b0;
        drain("drain_random");

        // Reset in the middle of a read aborts it without an ack.
        a_req[0] = 1'b1;
        a_we[0]  = 1'b0;
        a_addr[0] = 8'h04;
        seen = 1'b0;
        e    = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            step();
            if (granted[0]) begin
                seen = 1'b1;
                e    = gnt_edge[0];
            end
        end
        if (!seen) check("abort_grant_timeout", 32'(0), 32'(1));
        while (seen && cyc < e + 2) begin
            @(negedge clk);
            step();
        end
        #2;
        rst = 1'b1;
        reset_model();
        drive();
        #1;
        check("abort_rd_en", 32'(rd_en), 32'(0));
        check("abort_wr_en", 32'(wr_en), 32'(0));
        check("abort_busy",  32'(busy),  32'(0));
        check("abort_ack",   32'(ack),   32'(0));
        check("abort_abus",  32'(abus),  32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Fresh write then read-back from requester 0 after the abort.
        base = n_ack;
        a_req[0]   = 1'b1;
        a_we[0]    = 1'b1;
        a_addr[0]  = 8'h04;
        a_wdata[0] = 8'hA5;
        drain("drain_post_reset_write");
        a_req[0] = 1'b1;
        a_we[0]  = 1'b0;
        drain("drain_post_reset_read");
        check("post_reset_acks", 32'(n_ack - base), 32'(2));
        check("post_reset_rdata", 32'(rdata), 32'(8'hA5));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
